// File: rtl/quad_cmd_pkg.sv
// Shared definitions for the quadcopter command sequencer: opcodes, ACK byte,
// error codes and sequencer FSM states.
package quad_cmd_pkg;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] ACK       = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TMO      = 2'd1,
    ERR_NACK     = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_SETTLE,
    ST_COMPARE,
    ST_NEXT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/cmd_script_mem.sv
// Script storage: one synchronous write port, one asynchronous read port.
// Entry layout is {cmd, data, settle, mask}; contents are never reset.
module cmd_script_mem
  import quad_cmd_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned SETTLE_W = 24,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic                                 clk,
  input  logic                                 i_we,
  input  logic [$clog2(NUM_CMDS)-1:0]          i_waddr,
  input  logic [8+DW+SETTLE_W+NUM_CH-1:0]      i_wdata,
  input  logic [$clog2(NUM_CMDS)-1:0]          i_raddr,
  output logic [8+DW+SETTLE_W+NUM_CH-1:0]      o_rdata
);

  localparam int unsigned EW = 8 + DW + SETTLE_W + NUM_CH;

  logic [EW-1:0] r_mem [NUM_CMDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_sequencer.sv
// Replays a stored command script through the RemoteComm handshake, checks
// each ACK, then compares monitored channels to the commanded target.
module cmd_sequencer
  import quad_cmd_pkg::*;
#(
  parameter int unsigned NUM_CMDS    = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned SETTLE_W    = 24,
  parameter int unsigned TOL         = 8,
  parameter int unsigned RESP_TMO    = 2_000_000,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [$clog2(NUM_CMDS)-1:0]                   wr_addr,
  input  logic [7:0]                                    wr_cmd,
  input  logic [DW-1:0]                                 wr_data,
  input  logic [SETTLE_W-1:0]                           wr_settle,
  input  logic [NUM_CH-1:0]                             wr_mask,
  input  logic [$clog2(NUM_CMDS+1)-1:0]                 num_entries,
  input  logic                                          start,
  output logic [7:0]                                    cmd,
  output logic [DW-1:0]                                 data,
  output logic                                          send_cmd,
  input  logic                                          cmd_sent,
  input  logic                                          resp_rdy,
  input  logic [7:0]                                    resp,
  output logic                                          clr_resp_rdy,
  input  logic [NUM_CH*DW-1:0]                          mon_vals,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          pass,
  output logic [1:0]                                    err_code,
  output logic [$clog2(NUM_CMDS)-1:0]                   err_idx,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] err_ch
);

  localparam int unsigned AW  = $clog2(NUM_CMDS);
  localparam int unsigned NW  = $clog2(NUM_CMDS + 1);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TW  = $clog2(RESP_TMO + 1);
  localparam int unsigned EW  = 8 + DW + SETTLE_W + NUM_CH;

  state_e                r_state, w_nxt;
  logic [7:0]            r_cmd, w_cmd_n;
  logic [DW-1:0]         r_data, w_data_n;
  logic                  r_send, w_send_n;
  logic                  r_clr, w_clr_n;
  logic                  r_busy, w_busy_n;
  logic                  r_done, w_done_n;
  logic                  r_pass, w_pass_n;
  err_e                  r_err_code, w_err_code_n;
  logic [AW-1:0]         r_err_idx, w_err_idx_n;
  logic [CHW-1:0]        r_err_ch, w_err_ch_n;
  logic [AW-1:0]         r_idx, w_idx_n;
  logic [NW-1:0]         r_num, w_num_n;
  logic [TW-1:0]         r_tmo, w_tmo_n;
  logic [SETTLE_W-1:0]   r_cnt, w_cnt_n;

  logic [AW-1:0]         w_raddr;
  logic [EW-1:0]         w_rd;
  logic [7:0]            w_rd_cmd;
  logic [DW-1:0]         w_rd_data;
  logic [SETTLE_W-1:0]   w_rd_settle;
  logic [NUM_CH-1:0]     w_rd_mask;
  logic [NW-1:0]         w_num_sat;
  logic                  w_err;
  err_e                  w_err_kind;
  logic [CHW-1:0]        w_err_chv;
  logic                  w_mis;
  logic [CHW-1:0]        w_mis_ch;
  logic [DW-1:0]         w_mon  [NUM_CH];
  logic [DW:0]           w_diff [NUM_CH];
  logic [DW:0]           w_mag  [NUM_CH];

  // Entry being loaded into SEND is addressed one step ahead of r_idx.
  assign w_raddr = (r_state == ST_IDLE) ? '0 :
                   (r_state == ST_NEXT) ? r_idx + AW'(1) : r_idx;

  cmd_script_mem #(
    .NUM_CMDS (NUM_CMDS),
    .DW       (DW),
    .SETTLE_W (SETTLE_W),
    .NUM_CH   (NUM_CH)
  ) u_mem (
    .clk     (clk),
    .i_we    (wr_en & ~r_busy),
    .i_waddr (wr_addr),
    .i_wdata ({wr_cmd, wr_data, wr_settle, wr_mask}),
    .i_raddr (w_raddr),
    .o_rdata (w_rd)
  );

  assign w_rd_cmd    = w_rd[EW-1 -: 8];
  assign w_rd_data   = w_rd[DW+SETTLE_W+NUM_CH-1 -: DW];
  assign w_rd_settle = w_rd[SETTLE_W+NUM_CH-1 -: SETTLE_W];
  assign w_rd_mask   = w_rd[NUM_CH-1:0];
  assign w_num_sat   = (num_entries > NW'(NUM_CMDS)) ? NW'(NUM_CMDS) : num_entries;

  // Sign-extended difference in DW+1 bits; lowest failing masked channel wins.
  always_comb begin
    w_mis    = 1'b0;
    w_mis_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_mon[i]  = mon_vals[i*DW +: DW];
      w_diff[i] = {w_mon[i][DW-1], w_mon[i]} - {w_rd_data[DW-1], w_rd_data};
      w_mag[i]  = w_diff[i][DW] ? (~w_diff[i] + (DW+1)'(1)) : w_diff[i];
      if (!w_mis && w_rd_mask[i] && (w_mag[i] > (DW+1)'(TOL))) begin
        w_mis    = 1'b1;
        w_mis_ch = CHW'(i);
      end
    end
  end

  always_comb begin
    w_nxt        = r_state;
    w_cmd_n      = r_cmd;
    w_data_n     = r_data;
    w_send_n     = 1'b0;
    w_clr_n      = 1'b0;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_pass_n     = r_pass;
    w_err_code_n = r_err_code;
    w_err_idx_n  = r_err_idx;
    w_err_ch_n   = r_err_ch;
    w_idx_n      = r_idx;
    w_num_n      = r_num;
    w_tmo_n      = r_tmo;
    w_cnt_n      = r_cnt;
    w_err        = 1'b0;
    w_err_kind   = ERR_NONE;
    w_err_chv    = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pass_n     = 1'b0;
          w_err_code_n = ERR_NONE;
          w_err_idx_n  = '0;
          w_err_ch_n   = '0;
          w_idx_n      = '0;
          w_num_n      = w_num_sat;
          if (w_num_sat == '0) begin
            w_nxt = ST_FIN;
          end else begin
            w_busy_n = 1'b1;
            w_nxt    = ST_SEND;
          end
        end
      end
      ST_SEND: w_nxt = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (cmd_sent) begin
          w_tmo_n = '0;
          w_nxt   = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_rdy) begin
          w_clr_n = 1'b1;
          if (resp == ACK) begin
            w_cnt_n = '0;
            w_nxt   = ST_SETTLE;
          end else begin
            w_err      = 1'b1;
            w_err_kind = ERR_NACK;
          end
        end else if (r_tmo == TW'(RESP_TMO - 1)) begin
          w_err      = 1'b1;
          w_err_kind = ERR_TMO;
        end else begin
          w_tmo_n = r_tmo + TW'(1);
        end
      end
      ST_SETTLE: begin
        if (r_cnt == w_rd_settle) w_nxt = ST_COMPARE;
        else                      w_cnt_n = r_cnt + SETTLE_W'(1);
      end
      ST_COMPARE: begin
        if (w_mis) begin
          w_err      = 1'b1;
          w_err_kind = ERR_MISMATCH;
          w_err_chv  = w_mis_ch;
        end else begin
          w_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_idx_n = r_idx + AW'(1);
        if ((NW'(r_idx) + NW'(1)) >= r_num) w_nxt = ST_FIN;
        else                                w_nxt = ST_SEND;
      end
      ST_FIN:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase

    // Only the first error of a run is latched.
    if (w_err) begin
      if (r_err_code == ERR_NONE) begin
        w_err_code_n = w_err_kind;
        w_err_idx_n  = r_idx;
        w_err_ch_n   = w_err_chv;
      end
      w_nxt = (STOP_ON_ERR != 0) ? ST_FIN : ST_NEXT;
    end

    if (w_nxt == ST_SEND) begin
      w_send_n = 1'b1;
      w_cmd_n  = w_rd_cmd;
      w_data_n = w_rd_data;
    end

    if (w_nxt == ST_FIN) begin
      w_done_n = 1'b1;
      w_busy_n = 1'b0;
      w_pass_n = (w_err_code_n == ERR_NONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_data     <= '0;
      r_send     <= 1'b0;
      r_clr      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_idx  <= '0;
      r_err_ch   <= '0;
      r_idx      <= '0;
      r_num      <= '0;
      r_tmo      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nxt;
      r_cmd      <= w_cmd_n;
      r_data     <= w_data_n;
      r_send     <= w_send_n;
      r_clr      <= w_clr_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_pass     <= w_pass_n;
      r_err_code <= w_err_code_n;
      r_err_idx  <= w_err_idx_n;
      r_err_ch   <= w_err_ch_n;
      r_idx      <= w_idx_n;
      r_num      <= w_num_n;
      r_tmo      <= w_tmo_n;
      r_cnt      <= w_cnt_n;
    end
  end

  assign cmd          = r_cmd;
  assign data         = r_data;
  assign send_cmd     = r_send;
  assign clr_resp_rdy = r_clr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign err_code     = r_err_code;
  assign err_idx      = r_err_idx;
  assign err_ch       = r_err_ch;

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Parametrised, synthesizable host-command sequencer for the quadcopter bring-up rig. It replays a loaded script of flight commands through the RemoteComm send/response handshake and checks each ACK (0xA5). After each command it waits a programmable settle time, then compares up to NUM_CH monitored flight values against the commanded target within a tolerance. It supersedes hand-written bench sequences with an on-chip, self-checking equivalent usable in simulation and on the FPGA.

## Interface
- NUM_CMDS, 16: script depth (entries)
- NUM_CH, 4: monitored channels (0 ptch, 1 roll, 2 yaw, 3 thrst by convention)
- DW, 16: width of data and monitored values (signed)
- SETTLE_W, 24: settle counter width
- TOL, 8: allowed |mon − target| (unsigned, DW bits)
- RESP_TMO, 2_000_000: cycles to wait for resp_rdy after cmd_sent
- STOP_ON_ERR, 1: 1 = abort on first error; 0 = record first error, run to end
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  script write strobe (ignored while busy)
- wr_addr  in  $clog2(NUM_CMDS)  entry index
- wr_cmd  in  8  command opcode
- wr_data  in  DW  command data, also comparison target
- wr_settle  in  SETTLE_W  settle cycles after ACK
- wr_mask  in  NUM_CH  channels to compare for this entry
- num_entries  in  $clog2(NUM_CMDS+1)  entries to run, sampled at start; saturates at NUM_CMDS
- start  in  1  begin run (ignored while busy)
- cmd  out  8  to RemoteComm; reset 0
- data  out  DW  to RemoteComm; reset 0
- send_cmd  out  1  one-cycle pulse; reset 0
- cmd_sent  in  1  RemoteComm frame transmitted
- resp_rdy  in  1  response byte valid
- resp  in  8  response byte
- clr_resp_rdy  out  1  one-cycle pulse; reset 0
- mon_vals  in  NUM_CH*DW  packed monitored values, channel 0 in LSBs
- busy  out  1  reset 0
- done  out  1  one-cycle pulse at run end; reset 0
- pass  out  1  valid from done until next start; reset 0
- err_code  out  2  0 none, 1 resp timeout, 2 NACK, 3 mismatch; reset 0
- err_idx  out  $clog2(NUM_CMDS)  entry of first error; reset 0
- err_ch  out  $clog2(NUM_CH) (min 1)  first failing channel (lowest index); reset 0

## Operation
- States: IDLE → SEND → WAIT_SENT → WAIT_RESP → SETTLE → COMPARE → NEXT → (SEND | FIN) → IDLE.
- IDLE: start with num_entries=0 → FIN directly (pass=1). Otherwise clear err_*, idx=0, busy=1.
- SEND: drive cmd/data from entry idx, pulse send_cmd. Outputs held until the next SEND.
- WAIT_SENT: wait for cmd_sent (no timeout). WAIT_RESP: load timeout counter on entry; on resp_rdy pulse clr_resp_rdy and check resp: 0xA5 → SETTLE, else record NACK. Counter reaching RESP_TMO without resp_rdy → record timeout. resp_rdy in the expiry cycle counts as a response.
- SETTLE: count wr_settle cycles; 0 → COMPARE next cycle.
- COMPARE: in one cycle, for every masked channel, compute |sign-extended mon − data| in DW+1 bits; fail if > TOL. Mask 0 always passes.
- Error recording: only the first error latches err_code/err_idx/err_ch. STOP_ON_ERR=1 → FIN; else continue. NACK/timeout skip SETTLE/COMPARE.
- FIN: pass = (err_code==0), pulse done, busy=0.
- wr_en during busy: dropped. Memory contents are not reset.
- rst mid-run: all outputs to reset values immediately, FSM → IDLE; a RemoteComm transfer in flight is abandoned.

## Timing
- start at edge N → send_cmd high in cycle N+1.
- cmd_sent at N → WAIT_RESP from N+1; resp_rdy at M → clr_resp_rdy high at M+1.
- Settle of S cycles: COMPARE at M+1+S+1. COMPARE → NEXT → SEND: next send_cmd 2 cycles after compare.
- done asserts the cycle after the final COMPARE/NEXT, or the cycle after the aborting error.

## Structure
- quad_cmd_pkg: command opcodes (SET_PTCH 02, SET_ROLL 03, SET_YAW 04, SET_THRST 05, CALIBRATE 06, EMER_LAND 07, MTRS_OFF 08), ACK = 8'hA5, err_code enum, FSM state enum.
- Sub-module cmd_script_mem: NUM_CMDS × (8+DW+SETTLE_W+NUM_CH) register file, one write port, one asynchronous read port.

## Test plan
- Load [CALIBRATE 0000 settle 10 mask 0; SET_THRST 00FF settle 100 mask 1000], responder ACKs, thrst mon = 00FF → two send_cmd pulses, done, pass=1, err_code=0.
- SET_PTCH 0100 mask 0001, ptch mon = 0109 (TOL 8) → err_code=3, err_idx=0, err_ch=0, pass=0. Same test with 0108 → pass=1.
- SET_ROLL FF80 with roll mon = FF7A (negative, diff 6) → pass; mon = 0080 → mismatch (sign handling).
- Responder returns 0x5A on entry 1 of 3, STOP_ON_ERR=1 → err_code=2, err_idx=1, entry 2 never sent.
- No resp_rdy, RESP_TMO=50 → err_code=1 exactly 50 cycles into WAIT_RESP; resp_rdy on the 50th cycle → accepted.
- EMER_LAND 0000 mask 1111, all mons 0; assert rst during SETTLE → busy/send_cmd/done low immediately; restart runs clean.
